// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator with optional prefix chaining (IMM_PREFIX_EN)
module imm_gen_pipe #(
    parameter int DATA_W = 16,
    parameter int BR_W   = 9,
    parameter int MEM_W  = 4,
    parameter int IMM_W  = 8,
    parameter int PFX_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instr,
    input  logic [1:0]        imd_choice,
    input  logic              is_prefix,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] imm_out,
    output logic              imm_prefixed
);

    // Wide enough that a prefixed, sign-extended, shifted field never overflows before truncation.
    localparam int WIDE = DATA_W + PFX_W + 18;

    logic              accept;
    logic              load_out;
    logic              pfx_active;
    logic [PFX_W-1:0]  pfx;
    logic [7:0]        fw;
    logic [7:0]        n;
    logic [WIDE-1:0]   field;
    logic [WIDE-1:0]   comb_val;
    logic [WIDE-1:0]   sign_bit;
    logic [WIDE-1:0]   ext;
    logic [WIDE-1:0]   shifted;
    logic [DATA_W-1:0] imm_next;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef IMM_PREFIX_EN
    typedef enum logic {IDLE, PFX_HELD} state_t;
    state_t state, state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = is_prefix ? PFX_HELD : IDLE;
        end
    end

    always_comb begin
        pfx_active = (state == PFX_HELD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pfx <= '0;
        end else if (flush) begin
            pfx <= '0;
        end else if (accept && is_prefix) begin
            pfx <= instr[PFX_W-1:0];
        end
    end

    assign load_out = accept && !is_prefix;
`else
    logic unused_is_prefix;

    assign unused_is_prefix = is_prefix;
    assign pfx_active       = 1'b0;
    assign pfx              = '0;
    assign load_out         = accept;
`endif

    always_comb begin
        fw = 8'(IMM_W);
        case (imd_choice)
            2'b00:   fw = 8'(BR_W);
            2'b01:   fw = 8'(MEM_W);
            default: fw = 8'(IMM_W);
        endcase
    end

    // Sign extension by flipping and subtracting the top bit of the n-bit field.
    always_comb begin
        field    = WIDE'(instr) & ((WIDE'(1) << fw) - WIDE'(1));
        comb_val = field;
        n        = fw;
        if (pfx_active) begin
            comb_val = field | (WIDE'(pfx) << fw);
            n        = fw + 8'(PFX_W);
        end
        sign_bit = WIDE'(1) << (n - 8'd1);
        if (imd_choice == 2'b11) begin
            ext = comb_val;
        end else begin
            ext = (comb_val ^ sign_bit) - sign_bit;
        end
        shifted  = imd_choice[0] ? ext : (ext << 1);
        imm_next = DATA_W'(shifted);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            imm_out      <= '0;
            imm_prefixed <= 1'b0;
        end else if (flush) begin
            out_valid    <= 1'b0;
        end else if (load_out) begin
            out_valid    <= 1'b1;
            imm_out      <= imm_next;
            imm_prefixed <= pfx_active;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe, adapts to IMM_PREFIX_EN
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [1:0]  imd_choice;
    logic        is_prefix;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] imm_out;
    logic        imm_prefixed;

    int tests = 0;
    int fails = 0;

`ifdef IMM_PREFIX_EN
    localparam bit PFX_ON = 1'b1;
`else
    localparam bit PFX_ON = 1'b0;
`endif

    typedef struct {
        logic [15:0] imm;
        logic        pf;
    } exp_t;

    exp_t       q[$];
    bit         m_held;
    logic [7:0] m_pfx;
    bit         exp_ready;

    imm_gen_pipe #(
        .DATA_W(16), .BR_W(9), .MEM_W(4), .IMM_W(8), .PFX_W(8)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .imd_choice(imd_choice), .is_prefix(is_prefix),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .imm_out(imm_out), .imm_prefixed(imm_prefixed)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_imm(input logic [1:0] mode, input logic [15:0] ins,
                                              input bit held, input logic [7:0] p);
        longint w;
        longint n;
        longint f;
        case (mode)
            2'b00:   w = 9;
            2'b01:   w = 4;
            default: w = 8;
        endcase
        f = longint'(ins) & ((longint'(1) << w) - 1);
        n = w;
        if (held) begin
            f = f + (longint'(p) << w);
            n = n + 8;
        end
        if (mode != 2'b11 && ((f >> (n - 1)) & 1) == 1) f = f - (longint'(1) << n);
        if (mode[0] == 1'b0) f = f * 2;
        return 16'(f);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_held = 1'b0;
            m_pfx  = 8'h00;
        end else begin
            exp_ready = (q.size() == 0) || out_ready;
            check("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
            check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
            if (q.size() != 0) check("imm_out", {imm_prefixed, imm_out}, {q[0].pf, q[0].imm});
            if (flush) begin
                q.delete();
                m_held = 1'b0;
                m_pfx  = 8'h00;
            end else begin
                if (q.size() != 0 && out_ready) void'(q.pop_front());
                if (in_valid && exp_ready) begin
`ifdef IMM_PREFIX_EN
                    if (is_prefix) begin
                        m_held = 1'b1;
                        m_pfx  = instr[7:0];
                    end else begin
                        q.push_back('{model_imm(imd_choice, instr, m_held, m_pfx), m_held});
                        m_held = 1'b0;
                    end
`else
                    q.push_back('{model_imm(imd_choice, instr, 1'b0, 8'h00), 1'b0});
`endif
                end
            end
        end
    end

    task automatic beat(input bit p, input logic [1:0] m, input logic [15:0] ins);
        bit done = 1'b0;
        in_valid   = 1'b1;
        is_prefix  = p;
        imd_choice = m;
        instr      = ins;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        is_prefix = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL beat_timeout: got no accept expected accept within 20 cycles");
        end
    endtask

    task automatic expect_out(input logic [15:0] lit, input bit pf, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                check(name, {imm_prefixed, imm_out}, {pf, lit});
            end
            @(posedge clk);
            #1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no out_valid expected out_valid within 20 cycles", name);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; instr = 16'h0; imd_choice = 2'b00;
        is_prefix = 1'b0; flush = 1'b0; out_ready = 1'b1;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_imm", {16'd0, imm_out}, 32'h0);
        check("rst_pf", {31'd0, imm_prefixed}, 32'd0);

        check("model_br", {16'd0, model_imm(2'b00, 16'h01FF, 1'b0, 8'h00)}, 32'hFFFE);
        check("model_mem", {16'd0, model_imm(2'b01, 16'h0008, 1'b0, 8'h00)}, 32'hFFF8);
        check("model_pfx_mem", {16'd0, model_imm(2'b01, 16'h0004, 1'b1, 8'h12)}, 32'h0124);
        check("model_pfx_br", {16'd0, model_imm(2'b00, 16'h01FF, 1'b1, 8'h80)}, 32'h03FE);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        beat(1'b0, 2'b00, 16'h01FF); expect_out(16'hFFFE, 1'b0, "br_neg");
        beat(1'b0, 2'b01, 16'h0008); expect_out(16'hFFF8, 1'b0, "mem_neg");
        beat(1'b0, 2'b10, 16'h007F); expect_out(16'h00FE, 1'b0, "alu_pos");
        beat(1'b0, 2'b11, 16'h00F0); expect_out(16'h00F0, 1'b0, "zext");

        out_ready = 1'b0;
        beat(1'b0, 2'b01, 16'h0008);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_ready", {31'd0, in_ready}, 32'd0);
            check("stall_imm", {16'd0, imm_out}, 32'hFFF8);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        beat(1'b0, 2'b11, 16'h00F0); expect_out(16'h00F0, 1'b0, "after_stall");

        beat(1'b1, 2'b11, 16'h0012); beat(1'b0, 2'b11, 16'h0034);
        expect_out(PFX_ON ? 16'h1234 : 16'h0034, PFX_ON, "pfx_zext");
        beat(1'b1, 2'b11, 16'h0012); beat(1'b0, 2'b01, 16'h0004);
        expect_out(PFX_ON ? 16'h0124 : 16'h0004, PFX_ON, "pfx_mem_pos");
        beat(1'b1, 2'b11, 16'h00FF); beat(1'b0, 2'b01, 16'h0008);
        expect_out(16'hFFF8, PFX_ON, "pfx_mem_neg");
        beat(1'b1, 2'b11, 16'h0080); beat(1'b0, 2'b00, 16'h01FF);
        expect_out(PFX_ON ? 16'h03FE : 16'hFFFE, PFX_ON, "pfx_br_wide");

        beat(1'b1, 2'b11, 16'h0012);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        beat(1'b0, 2'b11, 16'h0034); expect_out(16'h0034, 1'b0, "flush_pfx");

        out_ready = 1'b0;
        beat(1'b0, 2'b01, 16'h0008);
        flush = 1'b1; in_valid = 1'b1; imd_choice = 2'b11; instr = 16'h0055;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;

        beat(1'b1, 2'b11, 16'h0011); beat(1'b1, 2'b11, 16'h0022); beat(1'b0, 2'b11, 16'h0033);
        expect_out(PFX_ON ? 16'h2233 : 16'h0033, PFX_ON, "two_pfx");

        out_ready = 1'b0;
        beat(1'b0, 2'b11, 16'h00AB);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_imm", {16'd0, imm_out}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("midrst_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        beat(1'b1, 2'b11, 16'h0012);
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        beat(1'b0, 2'b11, 16'h0034); expect_out(16'h0034, 1'b0, "rst_clears_pfx");

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
